// File: rtl/ip_datagram_rx.sv
// ip_datagram_rx: receive-side IPv4 parser.
// Checks the fixed 20-byte header, captures source address and payload length,
// then forwards the payload bytes. Trailing Ethernet padding is discarded.
module ip_datagram_rx #(
    parameter logic [7:0] PROTOCOL     = 8'd17,
    parameter bit         CHECK_CSUM   = 1'b1,
    parameter bit         ACCEPT_BCAST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cfg_local_ip,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_last,
    output logic [7:0]  pay_data,
    output logic        pay_valid,
    output logic        pay_last,
    output logic        pay_err,
    output logic [31:0] ip_src_addr,
    output logic [15:0] ip_pay_len,
    output logic        hdr_ok,
    output logic        hdr_err,
    output logic [2:0]  err_code
);

    typedef enum logic [1:0] {IDLE, HEADER, DATA, DROP} state_t;

    state_t        state_q, state_d;
    logic [4:0]    idx_q, idx_d;
    logic [19:0]   acc_q, acc_d;
    logic [151:0]  hdr_q, hdr_d;      // header bytes 0..18, byte 0 ends up on top
    logic [15:0]   rem_q, rem_d;
    logic [7:0]    pay_data_q, pay_data_d;
    logic          pay_valid_q, pay_valid_d;
    logic          pay_last_q, pay_last_d;
    logic          pay_err_q, pay_err_d;
    logic [31:0]   src_q, src_d;
    logic [15:0]   len_q, len_d;
    logic          hdr_ok_q, hdr_ok_d;
    logic          hdr_err_q, hdr_err_d;
    logic [2:0]    code_q, code_d;

    // Header view at byte 19: stored bytes plus the byte currently on the bus
    logic [159:0]  hdr_all;
    logic [4:0]    cur_idx;
    logic [19:0]   acc_base, acc_sum;
    logic [16:0]   fold1;
    logic [15:0]   fold2;
    logic [15:0]   totlen;
    logic [7:0]    b6, b7;
    logic          fmt_bad, csum_bad, proto_bad, dest_bad, len_bad;
    logic [2:0]    code;
    logic          unused_hdr;

    assign hdr_all  = {hdr_q, rx_data};
    assign cur_idx  = (state_q == IDLE) ? 5'd0 : idx_q;
    assign acc_base = (state_q == IDLE) ? 20'd0 : acc_q;
    // Even bytes are the high half of a 16-bit word, odd bytes the low half
    assign acc_sum  = acc_base + (cur_idx[0] ? {12'd0, rx_data} : {4'd0, rx_data, 8'd0});
    assign fold1    = {1'b0, acc_sum[15:0]} + {13'd0, acc_sum[19:16]};
    assign fold2    = fold1[15:0] + {15'd0, fold1[16]};

    assign totlen    = hdr_all[143:128];
    assign b6        = hdr_all[111:104];
    assign b7        = hdr_all[103:96];
    assign fmt_bad   = (hdr_all[159:152] != 8'h45) || b6[5] || ({b6[4:0], b7} != 13'd0);
    assign csum_bad  = CHECK_CSUM && (fold2 != 16'hFFFF);
    assign proto_bad = (hdr_all[87:80] != PROTOCOL);
    assign dest_bad  = (hdr_all[31:0] != cfg_local_ip) &&
                       !(ACCEPT_BCAST && (hdr_all[31:0] == 32'hFFFF_FFFF));
    assign len_bad   = (totlen < 16'd20);
    assign unused_hdr = ^{hdr_all[151:144], hdr_all[127:112], hdr_all[95:88], hdr_all[79:64]};

    // Error code: later assignments override, so the lowest failing code wins
    always_comb begin
        code = 3'd0;
        if (len_bad)   code = 3'd6;
        if (dest_bad)  code = 3'd4;
        if (proto_bad) code = 3'd3;
        if (csum_bad)  code = 3'd2;
        if (fmt_bad)   code = 3'd1;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        hdr_d       = hdr_q;
        rem_d       = rem_q;
        pay_data_d  = 8'd0;
        pay_valid_d = 1'b0;
        pay_last_d  = 1'b0;
        pay_err_d   = 1'b0;
        src_d       = src_q;
        len_d       = len_q;
        hdr_ok_d    = 1'b0;
        hdr_err_d   = 1'b0;
        code_d      = 3'd0;
        case (state_q)
            IDLE, HEADER: begin
                if (rx_valid) begin
                    hdr_d   = {hdr_q[143:0], rx_data};
                    acc_d   = acc_sum;
                    idx_d   = cur_idx + 5'd1;
                    state_d = HEADER;
                    if (cur_idx == 5'd19) begin
                        if (code == 3'd0) begin
                            hdr_ok_d = 1'b1;
                            src_d    = hdr_all[63:32];
                            len_d    = totlen - 16'd20;
                            rem_d    = totlen - 16'd20;
                            // A frame ending on the last header byte carries no payload
                            if (rx_last)                    state_d = IDLE;
                            else if (totlen == 16'd20)      state_d = DROP;
                            else                            state_d = DATA;
                        end else begin
                            hdr_err_d = 1'b1;
                            code_d    = code;
                            state_d   = rx_last ? IDLE : DROP;
                        end
                    end else if (rx_last) begin
                        hdr_err_d = 1'b1;
                        code_d    = 3'd5;
                        state_d   = IDLE;
                    end
                end
            end
            DATA: begin
                if (rx_valid) begin
                    pay_valid_d = 1'b1;
                    pay_data_d  = rx_data;
                    rem_d       = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        pay_last_d = 1'b1;
                        state_d    = rx_last ? IDLE : DROP;
                    end else if (rx_last) begin
                        pay_last_d = 1'b1;
                        pay_err_d  = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            DROP: begin
                if (rx_valid && rx_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 5'd0;
            acc_q       <= 20'd0;
            hdr_q       <= '0;
            rem_q       <= 16'd0;
            pay_data_q  <= 8'd0;
            pay_valid_q <= 1'b0;
            pay_last_q  <= 1'b0;
            pay_err_q   <= 1'b0;
            src_q       <= 32'd0;
            len_q       <= 16'd0;
            hdr_ok_q    <= 1'b0;
            hdr_err_q   <= 1'b0;
            code_q      <= 3'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            hdr_q       <= hdr_d;
            rem_q       <= rem_d;
            pay_data_q  <= pay_data_d;
            pay_valid_q <= pay_valid_d;
            pay_last_q  <= pay_last_d;
            pay_err_q   <= pay_err_d;
            src_q       <= src_d;
            len_q       <= len_d;
            hdr_ok_q    <= hdr_ok_d;
            hdr_err_q   <= hdr_err_d;
            code_q      <= code_d;
        end
    end

    assign pay_data    = pay_data_q;
    assign pay_valid   = pay_valid_q;
    assign pay_last    = pay_last_q;
    assign pay_err     = pay_err_q;
    assign ip_src_addr = src_q;
    assign ip_pay_len  = len_q;
    assign hdr_ok      = hdr_ok_q;
    assign hdr_err     = hdr_err_q;
    assign err_code    = code_q;

endmodule

// File: tb/tb_ip_datagram_rx.sv
// Scoreboard bench for ip_datagram_rx: two instances (checksum checked / ignored)
// share one input stream; each has its own expectation queue and monitor.
module tb_ip_datagram_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cfg_local_ip = 32'hC0A80114;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_last;

    logic [7:0]  pd1, pd2;
    logic        pv1, pv2, pl1, pl2, pe1, pe2, ok1, ok2, er1, er2;
    logic [31:0] src1, src2;
    logic [15:0] len1, len2;
    logic [2:0]  cd1, cd2;

    always #5 clk = ~clk;

    ip_datagram_rx #(.PROTOCOL(8'd17), .CHECK_CSUM(1'b1), .ACCEPT_BCAST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cfg_local_ip(cfg_local_ip),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last),
        .pay_data(pd1), .pay_valid(pv1), .pay_last(pl1), .pay_err(pe1),
        .ip_src_addr(src1), .ip_pay_len(len1), .hdr_ok(ok1), .hdr_err(er1), .err_code(cd1));

    ip_datagram_rx #(.PROTOCOL(8'd17), .CHECK_CSUM(1'b0), .ACCEPT_BCAST(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .cfg_local_ip(cfg_local_ip),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last),
        .pay_data(pd2), .pay_valid(pv2), .pay_last(pl2), .pay_err(pe2),
        .ip_src_addr(src2), .ip_pay_len(len2), .hdr_ok(ok2), .hdr_err(er2), .err_code(cd2));

    typedef struct packed {
        logic [1:0]  kind;   // 0 hdr_ok, 1 hdr_err, 2 payload beat
        logic [31:0] src;
        logic [15:0] len;
        logic [2:0]  code;
        logic [7:0]  data;
        logic        last;
        logic        err;
    } ev_t;

    ev_t         q1[$], q2[$];
    logic [7:0]  frm[$];
    int          checks = 0, errors = 0;
    logic [7:0]  refh [20] = '{8'h45, 8'h00, 8'h00, 8'h24, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                                8'hB7, 8'h5A, 8'hC0, 8'hA8, 8'h01, 8'h0A, 8'hC0, 8'hA8, 8'h01, 8'h14};

    localparam logic [31:0] SRC = 32'hC0A8010A;

    function automatic ev_t mk(logic [1:0] k, logic [31:0] s, logic [15:0] l, logic [2:0] c,
                               logic [7:0] d, logic la, logic er);
        ev_t e;
        e.kind = k; e.src = s; e.len = l; e.code = c; e.data = d; e.last = la; e.err = er;
        return e;
    endfunction

    // mask bit0 -> dut1 expectations, bit1 -> dut2 expectations
    task automatic push(input int m, input ev_t e);
        if (m[0]) q1.push_back(e);
        if (m[1]) q2.push_back(e);
    endtask

    task automatic exp_ok(input int m, input logic [15:0] l);
        push(m, mk(2'd0, SRC, l, 3'd0, 8'd0, 1'b0, 1'b0));
    endtask

    task automatic exp_err(input int m, input logic [2:0] c);
        push(m, mk(2'd1, 32'd0, 16'd0, c, 8'd0, 1'b0, 1'b0));
    endtask

    // Append n payload bytes 0..n-1; expectations go to mask m
    task automatic add_pay(input int m, input int n, input bit lastf, input bit errf);
        for (int i = 0; i < n; i++) begin
            frm.push_back(8'(i));
            push(m, mk(2'd2, 32'd0, 16'd0, 3'd0, 8'(i), lastf && (i == n - 1), errf && (i == n - 1)));
        end
    endtask

    task automatic load_ref();
        frm.delete();
        for (int i = 0; i < 20; i++) frm.push_back(refh[i]);
    endtask

    // Header with a correct checksum, source fixed at SRC
    task automatic build_hdr(input logic [7:0] vi, input logic [15:0] tl, input logic [7:0] b6,
                             input logic [7:0] pr, input logic [31:0] dst);
        logic [7:0]  h [20];
        logic [31:0] s;
        h = '{vi, 8'h00, tl[15:8], tl[7:0], 8'h00, 8'h00, b6, 8'h00, 8'h40, pr,
              8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h0A, dst[31:24], dst[23:16], dst[15:8], dst[7:0]};
        s = 32'd0;
        for (int i = 0; i < 20; i += 2) s = s + {16'd0, h[i], h[i+1]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        h[10] = ~s[15:8];
        h[11] = ~s[7:0];
        frm.delete();
        for (int i = 0; i < 20; i++) frm.push_back(h[i]);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0; rx_last = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic beat(input logic [7:0] d, input logic l);
        rx_data = d; rx_valid = 1'b1; rx_last = l;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_last = 1'b0;
    endtask

    task automatic send(input bit gaps);
        for (int i = 0; i < frm.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
            beat(frm[i], i == frm.size() - 1);
        end
        idle(2);
    endtask

    task automatic chk_zero(input string nm);
        checks++;
        if ({pd1, pv1, pl1, pe1, src1, len1, ok1, er1, cd1} !== '0) begin
            errors++;
            $display("FAIL %s dut1 outputs: got %h want 0", nm, {pd1, pv1, pl1, pe1, src1, len1, ok1, er1, cd1});
        end
        checks++;
        if ({pd2, pv2, pl2, pe2, src2, len2, ok2, er2, cd2} !== '0) begin
            errors++;
            $display("FAIL %s dut2 outputs: got %h want 0", nm, {pd2, pv2, pl2, pe2, src2, len2, ok2, er2, cd2});
        end
    endtask

    task automatic chk_empty(input string nm);
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL %s pending expectations: got %0d/%0d want 0/0", nm, q1.size(), q2.size());
        end
    endtask

    task automatic mon(input int id, input logic ok, input logic er, input logic [2:0] cd,
                       input logic [31:0] src, input logic [15:0] len, input logic pv,
                       input logic [7:0] pd, input logic pl, input logic pe);
        ev_t a, e;
        checks++;
        if (!pv && (pd != 8'd0 || pl || pe)) begin
            errors++;
            $display("FAIL dut%0d pay_idle: got data=%h last=%b err=%b want 0", id, pd, pl, pe);
        end
        checks++;
        if (ok && er) begin
            errors++;
            $display("FAIL dut%0d hdr_ok_and_err: got both want one", id);
        end
        if (ok || er || pv) begin
            if (ok)      a = mk(2'd0, src, len, 3'd0, 8'd0, 1'b0, 1'b0);
            else if (er) a = mk(2'd1, 32'd0, 16'd0, cd, 8'd0, 1'b0, 1'b0);
            else         a = mk(2'd2, 32'd0, 16'd0, 3'd0, pd, pl, pe);
            checks++;
            if ((id == 1 && q1.size() == 0) || (id == 2 && q2.size() == 0)) begin
                errors++;
                $display("FAIL dut%0d unexpected event: got %h want none", id, a);
            end else begin
                e = (id == 1) ? q1.pop_front() : q2.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL dut%0d event: got %h want %h", id, a, e);
                end
            end
        end
    endtask

    // Monitors: compare each presented event against the head of its queue
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            mon(1, ok1, er1, cd1, src1, len1, pv1, pd1, pl1, pe1);
            mon(2, ok2, er2, cd2, src2, len2, pv2, pd2, pl2, pe2);
        end
    end

    initial begin
        rst_n = 1'b0; rx_data = 8'd0; rx_valid = 1'b0; rx_last = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        idle(2);

        // T1 good frame
        load_ref(); exp_ok(3, 16'd16); add_pay(3, 16, 1'b1, 1'b0); send(1'b0);

        // T2 bad checksum: dropped when checked, accepted when ignored
        load_ref(); frm[11] = 8'h5B; exp_err(1, 3'd2); exp_ok(2, 16'd16);
        add_pay(2, 16, 1'b1, 1'b0); send(1'b0);

        // T3 protocol 06 + bad dest, checksum B764: protocol reported
        load_ref(); frm[9] = 8'h06; frm[10] = 8'hB7; frm[11] = 8'h64; frm[19] = 8'h15;
        exp_err(3, 3'd3); add_pay(0, 8, 1'b0, 1'b0); send(1'b0);

        // T4 TotLen 0x1A, 46-byte frame with padding and gaps, then a clean T1
        load_ref(); frm[3] = 8'h1A; frm[10] = 8'hB7; frm[11] = 8'h64;
        exp_ok(3, 16'd6); add_pay(3, 6, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) frm.push_back(8'hAA);
        send(1'b1);
        load_ref(); exp_ok(3, 16'd16); add_pay(3, 16, 1'b1, 1'b0); send(1'b1);

        // T5 header cut at byte 12; payload cut after 10 of 16
        load_ref(); for (int i = 0; i < 7; i++) void'(frm.pop_back());
        exp_err(3, 3'd5); send(1'b0);
        load_ref(); exp_ok(3, 16'd16); add_pay(3, 10, 1'b1, 1'b1); send(1'b0);

        // Single-byte frame is a short header
        frm.delete(); frm.push_back(8'h45); exp_err(3, 3'd5); send(1'b0);

        // Dest mismatch with correct protocol
        build_hdr(8'h45, 16'd36, 8'h00, 8'h11, 32'hC0A80115);
        exp_err(3, 3'd4); add_pay(0, 16, 1'b0, 1'b0); send(1'b0);

        // Broadcast accepted, one payload byte
        build_hdr(8'h45, 16'd21, 8'h40, 8'h11, 32'hFFFFFFFF);
        exp_ok(3, 16'd1); add_pay(3, 1, 1'b1, 1'b0); send(1'b0);

        // TotLen 19
        build_hdr(8'h45, 16'd19, 8'h00, 8'h11, 32'hC0A80114);
        exp_err(3, 3'd6); add_pay(0, 4, 1'b0, 1'b0); send(1'b0);

        // Bad version plus bad protocol: format wins
        build_hdr(8'h46, 16'd36, 8'h00, 8'h06, 32'hC0A80114);
        exp_err(3, 3'd1); add_pay(0, 16, 1'b0, 1'b0); send(1'b0);

        // More-fragments set
        build_hdr(8'h45, 16'd36, 8'h20, 8'h11, 32'hC0A80114);
        exp_err(3, 3'd1); add_pay(0, 16, 1'b0, 1'b0); send(1'b0);

        // Zero-length payload, frame ending on byte 19, then with trailing bytes
        build_hdr(8'h45, 16'd20, 8'h00, 8'h11, 32'hC0A80114);
        exp_ok(3, 16'd0); send(1'b0);
        build_hdr(8'h45, 16'd20, 8'h00, 8'h11, 32'hC0A80114);
        exp_ok(3, 16'd0); add_pay(0, 3, 1'b0, 1'b0); send(1'b0);

        // T6 reset while payload byte 5 is on the bus
        load_ref(); exp_ok(3, 16'd16); add_pay(3, 5, 1'b0, 1'b0);
        for (int i = 0; i < frm.size(); i++) beat(frm[i], 1'b0);
        @(negedge clk); #2;
        rx_data = 8'h05; rx_valid = 1'b1; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("mid_reset");
        chk_empty("before_reset_release");
        rx_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        idle(2);
        load_ref(); exp_ok(3, 16'd16); add_pay(3, 16, 1'b1, 1'b0); send(1'b0);

        idle(20);
        chk_empty("end");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
